// File: rtl/regs_forward_scoreboard.sv
// ID-stage operand resolver: GR/LLbit forwarding, pending-writer scoreboard
// for long-latency ops, RAW/WAW read-not-ready stall and stall-cycle counter.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid_i               ID holds a valid instruction
//   id_raddr_i, id_rdata_i   per-port read address / register-file data
//   id_we_i, id_waddr_i      ID destination write enable / register
//   id_llbit_i               architectural LLbit
//   fwd_*_i                  per-stage forwarding bundle (0 = youngest)
//   iss_valid_i, iss_waddr_i long-latency op issue
//   cmp_valid_i, cmp_waddr_i long-latency op completion
//   flush_i                  pipeline flush, clears the scoreboard
//   rdata_o, llbit_o         resolved operands / LLbit
//   read_ready_o             operands valid, ID may advance
//   iss_ready_o              destination counter not saturated
//   stall_cnt_o              saturating count of stalled cycles
module regs_forward_scoreboard #(
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid_i,
    input  logic [NUM_RD*ADDR_W-1:0]  id_raddr_i,
    input  logic [NUM_RD*DATA_W-1:0]  id_rdata_i,
    input  logic                      id_we_i,
    input  logic [ADDR_W-1:0]         id_waddr_i,
    input  logic                      id_llbit_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_dval_i,
    input  logic [NUM_FWD-1:0]        fwd_llbit_we_i,
    input  logic [NUM_FWD-1:0]        fwd_llbit_i,
    input  logic                      iss_valid_i,
    input  logic [ADDR_W-1:0]         iss_waddr_i,
    input  logic                      cmp_valid_i,
    input  logic [ADDR_W-1:0]         cmp_waddr_i,
    input  logic                      flush_i,
    output logic [NUM_RD*DATA_W-1:0]  rdata_o,
    output logic                      llbit_o,
    output logic                      read_ready_o,
    output logic                      iss_ready_o,
    output logic [31:0]               stall_cnt_o
);

    localparam int NREG = 1 << ADDR_W;

    logic [CNT_W-1:0]  pend [NREG];
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic              dv;
    logic              raw_fwd;
    logic              raw_sb;
    logic              waw_sb;
    logic              iss_fire;
    logic              cmp_fire;

    // Stages are scanned oldest-first so the youngest match overwrites.
    always_comb begin
        rdata_o = id_rdata_i;
        raw_fwd = 1'b0;
        raw_sb  = 1'b0;
        ra      = '0;
        hit     = 1'b0;
        dv      = 1'b1;
        for (int k = 0; k < NUM_RD; k++) begin
            ra  = id_raddr_i[k*ADDR_W +: ADDR_W];
            hit = 1'b0;
            dv  = 1'b1;
            for (int s = NUM_FWD - 1; s >= 0; s--) begin
                if (ra != '0 && fwd_we_i[s] &&
                    fwd_waddr_i[s*ADDR_W +: ADDR_W] == ra) begin
                    hit = 1'b1;
                    dv  = fwd_dval_i[s];
                    rdata_o[k*DATA_W +: DATA_W] =
                        fwd_wdata_i[s*DATA_W +: DATA_W];
                end
            end
            raw_fwd = raw_fwd | (hit & ~dv);
            raw_sb  = raw_sb | ((ra != '0) && (pend[ra] != '0));
        end
    end

    always_comb begin
        llbit_o = id_llbit_i;
        for (int s = NUM_FWD - 1; s >= 0; s--) begin
            if (fwd_llbit_we_i[s]) begin
                llbit_o = fwd_llbit_i[s];
            end
        end
    end

    assign waw_sb = id_we_i && (id_waddr_i != '0) &&
                    (pend[id_waddr_i] != '0);

    assign read_ready_o = ~(id_valid_i & (raw_fwd | raw_sb | waw_sb));
    assign iss_ready_o  = (pend[iss_waddr_i] != '1);

    // A flush cycle discards any same-cycle issue or completion.
    assign iss_fire = iss_valid_i & iss_ready_o & ~flush_i &
                      (iss_waddr_i != '0);
    assign cmp_fire = cmp_valid_i & ~flush_i & (cmp_waddr_i != '0);

    // Entry 0 is only ever written with zero, so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                pend[r] <= '0;
            end
        end else if (flush_i) begin
            for (int r = 0; r < NREG; r++) begin
                pend[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (iss_fire && iss_waddr_i == ADDR_W'(r) &&
                    !(cmp_fire && cmp_waddr_i == ADDR_W'(r))) begin
                    pend[r] <= pend[r] + CNT_W'(1);
                end else if (cmp_fire && cmp_waddr_i == ADDR_W'(r) &&
                             !(iss_fire && iss_waddr_i == ADDR_W'(r)) &&
                             pend[r] != '0) begin
                    pend[r] <= pend[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (!read_ready_o && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

`ifndef SYNTHESIS
    // Completion for a register with no pending writer is a pipeline bug.
    always @(posedge clk) begin
        if (!rst && cmp_fire &&
            !(iss_fire && iss_waddr_i == cmp_waddr_i)) begin
            assert (pend[cmp_waddr_i] != '0)
            else $error("scoreboard underflow on r%0d", cmp_waddr_i);
        end
    end
`endif

endmodule

// File: tb/tb_regs_forward_scoreboard.sv
// Randomised and directed bench for regs_forward_scoreboard, checked
// against a behavioural model of the forwarding and scoreboard rules.
module tb_regs_forward_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_raddr;
    logic [63:0] id_rdata;
    logic        id_we;
    logic [4:0]  id_waddr;
    logic        id_llbit;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_waddr;
    logic [63:0] fwd_wdata;
    logic [1:0]  fwd_dval;
    logic [1:0]  fwd_llbit_we;
    logic [1:0]  fwd_llbit;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic        cmp_valid;
    logic [4:0]  cmp_waddr;
    logic        flush;
    logic [63:0] rdata;
    logic        llbit;
    logic        read_ready;
    logic        iss_ready;
    logic [31:0] stall_cnt;

    int          tests;
    int          fails;
    int          pend_m [32];
    logic [31:0] stall_m;

    regs_forward_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid),
        .id_raddr_i     (id_raddr),
        .id_rdata_i     (id_rdata),
        .id_we_i        (id_we),
        .id_waddr_i     (id_waddr),
        .id_llbit_i     (id_llbit),
        .fwd_we_i       (fwd_we),
        .fwd_waddr_i    (fwd_waddr),
        .fwd_wdata_i    (fwd_wdata),
        .fwd_dval_i     (fwd_dval),
        .fwd_llbit_we_i (fwd_llbit_we),
        .fwd_llbit_i    (fwd_llbit),
        .iss_valid_i    (iss_valid),
        .iss_waddr_i    (iss_waddr),
        .cmp_valid_i    (cmp_valid),
        .cmp_waddr_i    (cmp_waddr),
        .flush_i        (flush),
        .rdata_o        (rdata),
        .llbit_o        (llbit),
        .read_ready_o   (read_ready),
        .iss_ready_o    (iss_ready),
        .stall_cnt_o    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] m_rdata(int k);
        logic [4:0] a;
        a = id_raddr[k*5 +: 5];
        if (a == 5'd0) return id_rdata[k*32 +: 32];
        for (int s = 0; s < 2; s++)
            if (fwd_we[s] && fwd_waddr[s*5 +: 5] == a)
                return fwd_wdata[s*32 +: 32];
        return id_rdata[k*32 +: 32];
    endfunction

    function automatic logic m_llbit();
        for (int s = 0; s < 2; s++)
            if (fwd_llbit_we[s]) return fwd_llbit[s];
        return id_llbit;
    endfunction

    function automatic logic m_ready();
        logic [4:0] a;
        if (!id_valid) return 1'b1;
        for (int k = 0; k < 2; k++) begin
            a = id_raddr[k*5 +: 5];
            if (a != 5'd0) begin
                if (pend_m[a] > 0) return 1'b0;
                for (int s = 0; s < 2; s++) begin
                    if (fwd_we[s] && fwd_waddr[s*5 +: 5] == a) begin
                        if (!fwd_dval[s]) return 1'b0;
                        break;
                    end
                end
            end
        end
        if (id_we && id_waddr != 5'd0 && pend_m[id_waddr] > 0)
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_iss_ready();
        return pend_m[iss_waddr] < 3;
    endfunction

    task automatic tick();
        logic r;
        logic ok;
        r  = m_ready();
        ok = m_iss_ready();
        @(posedge clk);
        if (flush) begin
            for (int i = 0; i < 32; i++) pend_m[i] = 0;
        end else begin
            if (iss_valid && ok && iss_waddr != 5'd0)
                pend_m[iss_waddr] = pend_m[iss_waddr] + 1;
            if (cmp_valid && cmp_waddr != 5'd0 && pend_m[cmp_waddr] > 0)
                pend_m[cmp_waddr] = pend_m[cmp_waddr] - 1;
        end
        if (!r && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_raddr = '0; id_rdata = '0;
        id_we = 0; id_waddr = '0; id_llbit = 0;
        fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
        fwd_dval = '1; fwd_llbit_we = '0; fwd_llbit = '0;
        iss_valid = 0; iss_waddr = '0;
        cmp_valid = 0; cmp_waddr = '0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        for (int i = 0; i < 32; i++) pend_m[i] = 0;
        stall_m = 0;
        id_valid = 1;
        id_raddr = {5'd5, 5'd3};
        id_rdata = {$urandom, $urandom};
        id_llbit = 1;
        #1;
        tests++;
        if (read_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got %b want 1", read_ready);
        end
        tests++;
        if (iss_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_iss_ready got %b want 1", iss_ready);
        end
        tests++;
        if (stall_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_stall got %h want 0", stall_cnt);
        end
        tests++;
        if (rdata !== id_rdata || llbit !== 1'b1) begin
            fails++;
            $display("FAIL reset_passthru got %h/%b want %h/1",
                     rdata, llbit, id_rdata);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        id_valid  = 1;
        id_rdata  = {32'hAAAA_0001, 32'hAAAA_0000};
        fwd_we    = 2'b11;
        fwd_waddr = {5'd5, 5'd5};
        fwd_wdata = {32'h22, 32'h11};
        fwd_dval  = 2'b11;
        id_raddr  = {5'd0, 5'd5};
        #1;
        tests++;
        if (rdata !== {32'hAAAA_0001, 32'h11} || read_ready !== 1'b1) begin
            fails++;
            $display("FAIL fwd_youngest got %h/%b want %h/1",
                     rdata, read_ready, {32'hAAAA_0001, 32'h11});
        end
        fwd_we = 2'b10;
        #1;
        tests++;
        if (rdata[31:0] !== 32'h22) begin
            fails++;
            $display("FAIL fwd_oldest got %h want 22", rdata[31:0]);
        end
        tick();
    endtask

    task automatic test_load_stall();
        logic [31:0] s0;
        logic [31:0] w;
        clear_inputs();
        w         = $urandom;
        id_valid  = 1;
        fwd_we    = 2'b01;
        fwd_waddr = {5'd0, 5'd7};
        fwd_wdata = {32'h0, w};
        fwd_dval  = 2'b00;
        id_raddr  = {5'd7, 5'd0};
        #1;
        tests++;
        if (read_ready !== 1'b0) begin
            fails++;
            $display("FAIL load_stall got %b want 0", read_ready);
        end
        s0 = stall_m;
        tick();
        tick();
        tests++;
        if (stall_cnt !== s0 + 32'd2) begin
            fails++;
            $display("FAIL load_stall_cnt got %0d want %0d",
                     stall_cnt, s0 + 32'd2);
        end
        fwd_dval = 2'b01;
        #1;
        tests++;
        if (read_ready !== 1'b1 || rdata[63:32] !== w) begin
            fails++;
            $display("FAIL load_resolved got %b/%h want 1/%h",
                     read_ready, rdata[63:32], w);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        iss_valid = 1; iss_waddr = 5'd9;
        tick();
        iss_valid = 0;
        id_valid  = 1; id_raddr = {5'd0, 5'd9};
        #1;
        tests++;
        if (read_ready !== 1'b0) begin
            fails++;
            $display("FAIL sb_raw got %b want 0", read_ready);
        end
        tick();
        cmp_valid = 1; cmp_waddr = 5'd9;
        #1;
        tests++;
        if (read_ready !== 1'b0) begin
            fails++;
            $display("FAIL sb_cmp_same_cycle got %b want 0", read_ready);
        end
        tick();
        cmp_valid = 0;
        #1;
        tests++;
        if (read_ready !== 1'b1) begin
            fails++;
            $display("FAIL sb_after_cmp got %b want 1", read_ready);
        end
        id_valid  = 0;
        iss_valid = 1;
        tick();
        cmp_valid = 1;
        tick();
        iss_valid = 0; cmp_valid = 0;
        id_valid  = 1;
        #1;
        tests++;
        if (read_ready !== 1'b0) begin
            fails++;
            $display("FAIL sb_iss_cmp_hold got %b want 0", read_ready);
        end
        id_valid = 0; cmp_valid = 1;
        tick();
        cmp_valid = 0; id_valid = 1;
        #1;
        tests++;
        if (read_ready !== 1'b1) begin
            fails++;
            $display("FAIL sb_drain got %b want 1", read_ready);
        end
        tick();
    endtask

    task automatic test_saturate();
        clear_inputs();
        iss_valid = 1; iss_waddr = 5'd3;
        repeat (4) tick();
        #1;
        tests++;
        if (iss_ready !== 1'b0) begin
            fails++;
            $display("FAIL sat_iss_ready got %b want 0", iss_ready);
        end
        iss_valid = 0;
        id_valid  = 1; id_raddr = {5'd3, 5'd0};
        #1;
        tests++;
        if (read_ready !== 1'b0) begin
            fails++;
            $display("FAIL sat_raw got %b want 0", read_ready);
        end
        id_raddr  = '0;
        id_rdata  = {$urandom, $urandom};
        fwd_we    = 2'b11;
        fwd_waddr = '0;
        fwd_dval  = 2'b00;
        fwd_wdata = {32'hDEAD_BEEF, 32'hCAFE_F00D};
        #1;
        tests++;
        if (read_ready !== 1'b1 || rdata !== id_rdata) begin
            fails++;
            $display("FAIL r0_no_match got %b/%h want 1/%h",
                     read_ready, rdata, id_rdata);
        end
        iss_waddr = 5'd4;
        #1;
        tests++;
        if (iss_ready !== 1'b1) begin
            fails++;
            $display("FAIL iss_ready_other got %b want 1", iss_ready);
        end
        tick();
    endtask

    task automatic test_flush();
        clear_inputs();
        iss_valid = 1; iss_waddr = 5'd4;
        tick();
        tick();
        iss_valid = 0;
        flush = 1; cmp_valid = 1; cmp_waddr = 5'd4;
        tick();
        flush = 0; cmp_valid = 0;
        id_valid = 1; id_we = 1; id_waddr = 5'd4;
        id_raddr = {5'd3, 5'd4};
        iss_waddr = 5'd3;
        #1;
        tests++;
        if (read_ready !== 1'b1 || iss_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_clear got %b/%b want 1/1",
                     read_ready, iss_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        iss_valid = 1; iss_waddr = 5'd6;
        tick();
        iss_valid = 0;
        id_valid  = 1; id_raddr = {5'd6, 5'd0};
        tick();
        tick();
        tests++;
        if (stall_cnt !== stall_m || read_ready !== 1'b0) begin
            fails++;
            $display("FAIL pre_reset got %0d/%b want %0d/0",
                     stall_cnt, read_ready, stall_m);
        end
        #2;
        rst = 1;
        for (int i = 0; i < 32; i++) pend_m[i] = 0;
        stall_m = 0;
        #1;
        tests++;
        if (stall_cnt !== 32'd0 || read_ready !== 1'b1 ||
            iss_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset got %0d/%b/%b want 0/1/1",
                     stall_cnt, read_ready, iss_ready);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_random();
        int c;
        logic [31:0] e0;
        logic [31:0] e1;
        for (int n = 0; n < 400; n++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_raddr     = {5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7))};
            id_rdata     = {$urandom, $urandom};
            id_we        = $urandom_range(0, 1);
            id_waddr     = 5'($urandom_range(0, 7));
            id_llbit     = $urandom_range(0, 1);
            fwd_we       = 2'($urandom_range(0, 3));
            fwd_waddr    = {5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7))};
            fwd_wdata    = {$urandom, $urandom};
            fwd_dval     = 2'($urandom_range(0, 3)) |
                           2'($urandom_range(0, 3));
            fwd_llbit_we = 2'($urandom_range(0, 3));
            fwd_llbit    = 2'($urandom_range(0, 3));
            iss_valid    = ($urandom_range(0, 3) == 0);
            iss_waddr    = 5'($urandom_range(0, 7));
            c            = $urandom_range(0, 7);
            cmp_waddr    = 5'(c);
            cmp_valid    = ($urandom_range(0, 2) == 0) &&
                           (pend_m[c] > 0 ||
                            (iss_valid && iss_waddr == 5'(c) &&
                             pend_m[c] < 3));
            flush        = ($urandom_range(0, 19) == 0);
            #1;
            e0 = m_rdata(0);
            e1 = m_rdata(1);
            tests++;
            if (rdata !== {e1, e0}) begin
                fails++;
                $display("FAIL rnd_rdata #%0d got %h want %h",
                         n, rdata, {e1, e0});
            end
            tests++;
            if (llbit !== m_llbit()) begin
                fails++;
                $display("FAIL rnd_llbit #%0d got %b want %b",
                         n, llbit, m_llbit());
            end
            tests++;
            if (read_ready !== m_ready()) begin
                fails++;
                $display("FAIL rnd_ready #%0d got %b want %b",
                         n, read_ready, m_ready());
            end
            tests++;
            if (iss_ready !== m_iss_ready()) begin
                fails++;
                $display("FAIL rnd_iss_ready #%0d got %b want %b",
                         n, iss_ready, m_iss_ready());
            end
            tick();
            tests++;
            if (stall_cnt !== stall_m) begin
                fails++;
                $display("FAIL rnd_stall_cnt #%0d got %0d want %0d",
                         n, stall_cnt, stall_m);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_fwd_priority();
        test_load_stall();
        test_scoreboard();
        test_saturate();
        test_flush();
        test_reset_mid();
        test_random();
        clear_inputs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
